// File: rtl/ifetch_buffer.sv
// Fetch front end: owns the fetch PC, issues word reads to a 1-cycle inst_ram and queues the
// returned instructions in a DEPTH-entry FIFO with a valid/ready handshake toward decode.
module ifetch_buffer #(
   parameter int               XLEN     = 32,
   parameter int               ILEN     = 32,
   parameter int               ADDR_W   = 8,
   parameter int               DEPTH    = 2,
   parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [ILEN-1:0]   imem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ILEN-1:0]   out_instr,
   output logic [XLEN-1:0]   out_pc
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 1;
   localparam logic [XLEN-1:0] PC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] issue_pc_q, issue_pc_d;
   logic            inflight_q, inflight_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [ILEN-1:0] instr_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_q    [DEPTH];

   logic pop_s;
   logic push_s;
   logic credit_s;
   logic issue_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   // Slots already claimed (queued + in flight) must leave room for one more response.
   assign pop_s    = out_valid & out_ready;
   assign credit_s = (({1'b0, count_q} + SW'(inflight_q)) - SW'(pop_s)) < SW'(DEPTH);
   assign issue_s  = ~rst & ~redirect_valid & credit_s;
   assign push_s   = inflight_q & ~redirect_valid;

   assign imem_en   = issue_s;
   assign imem_addr = pc_q[ADDR_W+1:2];
   assign out_valid = (count_q != {CW{1'b0}});
   assign out_instr = instr_mem_q[rd_ptr_q];
   assign out_pc    = pc_mem_q[rd_ptr_q];

   // Next-state for PC, in-flight tracking and FIFO bookkeeping; a redirect flushes everything.
   always_comb begin
      pc_d       = pc_q;
      issue_pc_d = issue_pc_q;
      inflight_d = inflight_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect_valid) begin
         pc_d       = redirect_pc & PC_MASK;
         inflight_d = 1'b0;
         rd_ptr_d   = {PW{1'b0}};
         wr_ptr_d   = {PW{1'b0}};
         count_d    = {CW{1'b0}};
      end else begin
         if (issue_s) begin
            pc_d       = pc_q + XLEN'(4);
            issue_pc_d = pc_q;
         end else begin
            pc_d       = pc_q;
            issue_pc_d = issue_pc_q;
         end
         inflight_d = issue_s;
         rd_ptr_d   = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
         wr_ptr_d   = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
         count_d    = count_q + CW'(push_s) - CW'(pop_s);
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC & PC_MASK;
         issue_pc_q <= {XLEN{1'b0}};
         inflight_q <= 1'b0;
         rd_ptr_q   <= {PW{1'b0}};
         wr_ptr_q   <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
      end else begin
         pc_q       <= pc_d;
         issue_pc_q <= issue_pc_d;
         inflight_q <= inflight_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage; cleared on reset so the head outputs read zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem_q[i] <= {ILEN{1'b0}};
            pc_mem_q[i]    <= {XLEN{1'b0}};
         end
      end else if (push_s) begin
         instr_mem_q[wr_ptr_q] <= imem_rdata;
         pc_mem_q[wr_ptr_q]    <= issue_pc_q;
      end
   end

endmodule
